commutation_sequencer: RTL and testbench

Six-step (trapezoidal) BLDC commutation sequencer that owns the six gate-drive outputs `PHASES[5:0]` on the motor board. It filters the three Hall inputs, decodes the rotor sector, and sequences the matching high/low-side pattern. Every pattern change is separated by a dead-time gap, and the high side is PWM-gated from a duty command. It sits between the Hall input pads and the phase pins, downstream of the position/current controller that supplies `duty` and `direction`.

---
 rtl/commutation_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_commutation_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commutation_sequencer.sv
// Six-step BLDC commutation sequencer: filters the Hall inputs, decodes the rotor
// sector and drives the matching gate pattern with dead time, PWM and faults.
module commutation_sequencer #(
    parameter int PWM_BITS      = 10,
    parameter int DEADTIME      = 16,
    parameter int HALL_FILTER   = 3,
    parameter int STALL_TIMEOUT = 1600000
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic                direction,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                hall1,
    input  logic                hall2,
    input  logic                hall3,
    output logic [5:0]          PHASES,
    output logic [2:0]          sector,
    output logic                commutation_strobe,
    output logic                fault,
    output logic [1:0]          fault_code
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DEAD  = 2'd1,
        RUN   = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync1_q, sync2_q, hallLast_q;
    logic [2:0]          acc_q, acc_d;
    logic [3:0]          filtCnt_q, filtCnt_d;
    logic [2:0]          sector_q, sector_d;
    logic [2:0]          target_q, target_d;
    logic [7:0]          deadCnt_q, deadCnt_d;
    logic [23:0]         stallCnt_q, stallCnt_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d, dutyLat_q, dutyLat_d;
    logic                dir_q;
    logic [5:0]          phases_q, phases_d;
    logic                strobe_q, strobe_d;
    logic                fault_q, fault_d;
    logic [1:0]          code_q, code_d;

    logic [2:0] curSec, driveSec;
    logic       accValid, sectorChange, counting, stallHit, hiOn;

    function automatic logic [2:0] decodeHall(input logic [2:0] c);
        case (c)
            3'b101:  decodeHall = 3'd0;
            3'b100:  decodeHall = 3'd1;
            3'b110:  decodeHall = 3'd2;
            3'b010:  decodeHall = 3'd3;
            3'b011:  decodeHall = 3'd4;
            3'b001:  decodeHall = 3'd5;
            default: decodeHall = 3'd7;
        endcase
    endfunction

    // Returns {CL,BL,AL,CH,BH,AH}; the high-side bit is masked by the PWM gate.
    function automatic logic [5:0] drivePattern(input logic [2:0] s, input logic on);
        logic [2:0] hi;
        logic [2:0] lo;
        hi = 3'b000;
        lo = 3'b000;
        case (s)
            3'd0: begin hi = 3'b001; lo = 3'b010; end
            3'd1: begin hi = 3'b001; lo = 3'b100; end
            3'd2: begin hi = 3'b010; lo = 3'b100; end
            3'd3: begin hi = 3'b010; lo = 3'b001; end
            3'd4: begin hi = 3'b100; lo = 3'b001; end
            3'd5: begin hi = 3'b100; lo = 3'b010; end
            default: begin hi = 3'b000; lo = 3'b000; end
        endcase
        drivePattern = {lo, on ? hi : 3'b000};
    endfunction

    // The Hall data path carries no reset so an already accepted code survives a reset pulse.
    always_ff @(posedge CLK) begin
        sync1_q    <= {hall3, hall2, hall1};
        sync2_q    <= sync1_q;
        hallLast_q <= sync2_q;
        acc_q      <= acc_d;
    end

    assign acc_d        = (filtCnt_q == 4'(HALL_FILTER)) ? hallLast_q : acc_q;
    assign sectorChange = (filtCnt_q == 4'(HALL_FILTER)) && (hallLast_q != acc_q)
                          && (decodeHall(hallLast_q) != 3'd7);
    assign sector_d     = (decodeHall(acc_d) != 3'd7) ? decodeHall(acc_d) : sector_q;
    assign curSec       = decodeHall(acc_q);
    assign accValid     = (curSec != 3'd7);
    assign driveSec     = !dir_q ? curSec : ((curSec >= 3'd3) ? curSec - 3'd3 : curSec + 3'd3);

    always_comb begin
        filtCnt_d = filtCnt_q;
        if (sync2_q != hallLast_q) begin
            filtCnt_d = 4'd1;
        end else if (filtCnt_q != 4'(HALL_FILTER)) begin
            filtCnt_d = filtCnt_q + 4'd1;
        end
    end

    assign pwm_d     = pwm_q + PWM_BITS'(1);
    assign dutyLat_d = (pwm_q == '1) ? duty : dutyLat_q;
    assign hiOn      = (pwm_d < dutyLat_d);

    assign counting = ((state_q == DEAD) || (state_q == RUN)) && (dutyLat_q != '0);
    assign stallHit = counting && !sectorChange && (stallCnt_q == 24'(STALL_TIMEOUT - 1));

    // Fault checks follow the normal transitions so they override them; enable=0 overrides all.
    always_comb begin
        state_d    = state_q;
        deadCnt_d  = deadCnt_q;
        target_d   = target_q;
        stallCnt_d = stallCnt_q;
        fault_d    = fault_q;
        code_d     = code_q;
        phases_d   = 6'b000000;
        strobe_d   = 1'b0;

        if (sectorChange) begin
            stallCnt_d = '0;
        end else if (counting) begin
            stallCnt_d = stallCnt_q + 24'd1;
        end

        case (state_q)
            IDLE: begin
                if (enable && accValid) begin
                    state_d    = DEAD;
                    deadCnt_d  = 8'(DEADTIME - 1);
                    target_d   = driveSec;
                    stallCnt_d = '0;
                end
            end
            DEAD: begin
                if (driveSec != target_q) begin
                    deadCnt_d = 8'(DEADTIME - 1);
                    target_d  = driveSec;
                end else if (deadCnt_q == 8'd0) begin
                    state_d = RUN;
                end else begin
                    deadCnt_d = deadCnt_q - 8'd1;
                end
            end
            RUN: begin
                if (driveSec != target_q) begin
                    state_d   = DEAD;
                    deadCnt_d = 8'(DEADTIME - 1);
                    target_d  = driveSec;
                end
            end
            default: begin
            end
        endcase

        if ((state_q == DEAD) || (state_q == RUN)) begin
            if (!accValid) begin
                state_d = FAULT;
                fault_d = 1'b1;
                code_d  = 2'b01;
            end else if (stallHit) begin
                state_d = FAULT;
                fault_d = 1'b1;
                code_d  = 2'b10;
            end
        end

        if (!enable) begin
            state_d = IDLE;
            fault_d = 1'b0;
            code_d  = 2'b00;
        end

        if (state_d == RUN) begin
            phases_d = drivePattern(target_d, hiOn);
        end
        strobe_d = (state_q == DEAD) && (state_d == RUN);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            filtCnt_q  <= '0;
            sector_q   <= 3'd7;
            target_q   <= '0;
            deadCnt_q  <= '0;
            stallCnt_q <= '0;
            pwm_q      <= '0;
            dutyLat_q  <= '0;
            dir_q      <= 1'b0;
            phases_q   <= '0;
            strobe_q   <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            filtCnt_q  <= filtCnt_d;
            sector_q   <= sector_d;
            target_q   <= target_d;
            deadCnt_q  <= deadCnt_d;
            stallCnt_q <= stallCnt_d;
            pwm_q      <= pwm_d;
            dutyLat_q  <= dutyLat_d;
            dir_q      <= direction;
            phases_q   <= phases_d;
            strobe_q   <= strobe_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
        end
    end

    assign PHASES             = phases_q;
    assign sector             = sector_q;
    assign commutation_strobe = strobe_q;
    assign fault              = fault_q;
    assign fault_code         = code_q;

endmodule

// File: tb/tb_commutation_sequencer.sv
// Directed bench for commutation_sequencer with PWM_BITS=4, DEADTIME=4,
// HALL_FILTER=3 and STALL_TIMEOUT=200; inputs change #1 after the rising edge.
module tb_commutation_sequencer;

    logic       CLK = 1'b0;
    logic       reset;
    logic       enable;
    logic       direction;
    logic [3:0] duty;
    logic       hall1, hall2, hall3;
    logic [5:0] PHASES;
    logic [2:0] sector;
    logic       commutation_strobe;
    logic       fault;
    logic [1:0] fault_code;

    int testsRun = 0;
    int testsFailed = 0;

    commutation_sequencer #(
        .PWM_BITS(4), .DEADTIME(4), .HALL_FILTER(3), .STALL_TIMEOUT(200)
    ) dut (
        .CLK(CLK), .reset(reset), .enable(enable), .direction(direction), .duty(duty),
        .hall1(hall1), .hall2(hall2), .hall3(hall3), .PHASES(PHASES), .sector(sector),
        .commutation_strobe(commutation_strobe), .fault(fault), .fault_code(fault_code)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic setHall(input logic [2:0] code);
        {hall3, hall2, hall1} = code;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; direction = 1'b0; duty = 4'd15;
        setHall(3'b101);
        tick(3);
        testsRun++;
        if (PHASES !== 6'b0 || commutation_strobe !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs: phases=%b strobe=%b, wanted 000000/0", PHASES, commutation_strobe);
        end
        testsRun++;
        if (sector !== 3'd7 || fault !== 1'b0 || fault_code !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_status: sector=%0d fault=%b code=%b, wanted 7/0/00", sector, fault, fault_code);
        end
        reset = 1'b0;
        tick(10);
        testsRun++;
        if (sector !== 3'd0 || PHASES !== 6'b0) begin
            testsFailed++;
            $display("[TB] FAIL idle_accept: sector=%0d phases=%b, wanted 0/000000", sector, PHASES);
        end
        enable = 1'b1;
        tick(10);
        reset = 1'b1;
        #1;
        testsRun++;
        if (PHASES !== 6'b0 || sector !== 3'd7) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: phases=%b sector=%0d, wanted 000000/7", PHASES, sector);
        end
        tick(2);
        reset = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            tick(1);
            testsRun++;
            if (PHASES !== 6'b0 || commutation_strobe !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL reset_dead%0d: phases=%b strobe=%b, wanted 000000/0", j, PHASES, commutation_strobe);
            end
        end
        testsRun++;
        if (sector !== 3'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_sector: got %0d wanted 0", sector);
        end
        tick(1);
        testsRun++;
        if ((PHASES & 6'b111110) !== 6'b010000 || commutation_strobe !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_run: phases=%b strobe=%b, wanted 01000x/1", PHASES, commutation_strobe);
        end
        tick(1);
        testsRun++;
        if (commutation_strobe !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_strobe_len: got %b wanted 0", commutation_strobe);
        end
    endtask

    task automatic test_filter();
        enable = 1'b0; direction = 1'b0; duty = 4'd15;
        setHall(3'b101);
        tick(20);
        enable = 1'b1;
        tick(10);
        testsRun++;
        if ((PHASES & 6'b111110) !== 6'b010000) begin
            testsFailed++;
            $display("[TB] FAIL filter_start: phases=%b wanted 01000x", PHASES);
        end
        setHall(3'b100);
        tick(5);
        testsRun++;
        if (sector !== 3'd0 || (PHASES & 6'b111000) !== 6'b010000) begin
            testsFailed++;
            $display("[TB] FAIL filter_early: sector=%0d phases=%b, wanted 0/010xxx", sector, PHASES);
        end
        tick(1);
        testsRun++;
        if (sector !== 3'd1 || (PHASES & 6'b111000) !== 6'b010000) begin
            testsFailed++;
            $display("[TB] FAIL filter_accept: sector=%0d phases=%b, wanted 1/010xxx", sector, PHASES);
        end
        for (int j = 0; j < 4; j++) begin
            tick(1);
            testsRun++;
            if (PHASES !== 6'b0) begin
                testsFailed++;
                $display("[TB] FAIL filter_dead%0d: phases=%b wanted 000000", j, PHASES);
            end
        end
        tick(1);
        testsRun++;
        if ((PHASES & 6'b111110) !== 6'b100000 || commutation_strobe !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL filter_new: phases=%b strobe=%b, wanted 10000x/1", PHASES, commutation_strobe);
        end
        tick(1);
        setHall(3'b110);
        tick(2);
        setHall(3'b100);
        for (int j = 0; j < 12; j++) begin
            tick(1);
            testsRun++;
            if ((PHASES & 6'b111110) !== 6'b100000 || commutation_strobe !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL glitch%0d: phases=%b strobe=%b, wanted 10000x/0", j, PHASES, commutation_strobe);
            end
        end
    endtask

    task automatic test_reverse_pwm();
        int chOn;
        int alOn;
        enable = 1'b0; direction = 1'b1; duty = 4'd15;
        setHall(3'b100);
        tick(20);
        testsRun++;
        if (sector !== 3'd1) begin
            testsFailed++;
            $display("[TB] FAIL rev_sector: got %0d wanted 1", sector);
        end
        enable = 1'b1;
        tick(6);
        testsRun++;
        if ((PHASES & 6'b111011) !== 6'b001000) begin
            testsFailed++;
            $display("[TB] FAIL rev_pattern: phases=%b wanted 001x00", PHASES);
        end
        duty = 4'd5;
        tick(17);
        chOn = 0; alOn = 0;
        for (int j = 0; j < 16; j++) begin
            tick(1);
            if (PHASES[2]) chOn++;
            if (PHASES[3]) alOn++;
        end
        testsRun++;
        if (chOn !== 5 || alOn !== 16) begin
            testsFailed++;
            $display("[TB] FAIL pwm_duty5: ch=%0d al=%0d, wanted 5/16", chOn, alOn);
        end
        duty = 4'd0;
        tick(17);
        chOn = 0; alOn = 0;
        for (int j = 0; j < 16; j++) begin
            tick(1);
            if (PHASES[2]) chOn++;
            if (PHASES[3]) alOn++;
        end
        testsRun++;
        if (chOn !== 0 || alOn !== 16) begin
            testsFailed++;
            $display("[TB] FAIL pwm_duty0: ch=%0d al=%0d, wanted 0/16", chOn, alOn);
        end
    endtask

    task automatic test_invalid();
        enable = 1'b0; direction = 1'b0; duty = 4'd15;
        setHall(3'b101);
        tick(20);
        enable = 1'b1;
        tick(8);
        setHall(3'b111);
        tick(3);
        setHall(3'b101);
        tick(3);
        testsRun++;
        if (fault !== 1'b0 || (PHASES & 6'b111000) !== 6'b010000) begin
            testsFailed++;
            $display("[TB] FAIL invalid_early: fault=%b phases=%b, wanted 0/010xxx", fault, PHASES);
        end
        tick(1);
        testsRun++;
        if (fault !== 1'b1 || fault_code !== 2'b01 || PHASES !== 6'b0) begin
            testsFailed++;
            $display("[TB] FAIL invalid_fault: fault=%b code=%b phases=%b, wanted 1/01/000000", fault, fault_code, PHASES);
        end
        tick(15);
        testsRun++;
        if (fault !== 1'b1 || fault_code !== 2'b01 || PHASES !== 6'b0) begin
            testsFailed++;
            $display("[TB] FAIL invalid_sticky: fault=%b code=%b phases=%b, wanted 1/01/000000", fault, fault_code, PHASES);
        end
        enable = 1'b0;
        tick(1);
        testsRun++;
        if (fault !== 1'b0 || fault_code !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL invalid_clear: fault=%b code=%b, wanted 0/00", fault, fault_code);
        end
        enable = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick(1);
            testsRun++;
            if (PHASES !== 6'b0) begin
                testsFailed++;
                $display("[TB] FAIL rearm_dead%0d: phases=%b wanted 000000", j, PHASES);
            end
        end
        tick(1);
        testsRun++;
        if ((PHASES & 6'b111110) !== 6'b010000) begin
            testsFailed++;
            $display("[TB] FAIL rearm_run: phases=%b wanted 01000x", PHASES);
        end
    endtask

    task automatic test_stall();
        enable = 1'b0; direction = 1'b0; duty = 4'd8;
        setHall(3'b101);
        tick(20);
        enable = 1'b1;
        tick(200);
        testsRun++;
        if (fault !== 1'b0 || fault_code !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL stall_early: fault=%b code=%b, wanted 0/00", fault, fault_code);
        end
        tick(1);
        testsRun++;
        if (fault !== 1'b1 || fault_code !== 2'b10 || PHASES !== 6'b0) begin
            testsFailed++;
            $display("[TB] FAIL stall_fault: fault=%b code=%b phases=%b, wanted 1/10/000000", fault, fault_code, PHASES);
        end
        enable = 1'b0; duty = 4'd0;
        tick(20);
        enable = 1'b1;
        tick(1000);
        testsRun++;
        if (fault !== 1'b0 || fault_code !== 2'b00 || PHASES !== 6'b010000) begin
            testsFailed++;
            $display("[TB] FAIL stall_duty0: fault=%b code=%b phases=%b, wanted 0/00/010000", fault, fault_code, PHASES);
        end
    endtask

    task automatic test_back_to_back();
        int zeroCount;
        int strobeCount;
        enable = 1'b0; direction = 1'b0; duty = 4'd15;
        setHall(3'b101);
        tick(20);
        enable = 1'b1;
        tick(8);
        zeroCount = 0; strobeCount = 0;
        direction = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            tick(1);
            if (j == 2) direction = 1'b0;
            if (PHASES == 6'b0) zeroCount++;
            if (commutation_strobe) strobeCount++;
            if (j == 1) begin
                testsRun++;
                if ((PHASES & 6'b111000) !== 6'b010000) begin
                    testsFailed++;
                    $display("[TB] FAIL restart_pre: phases=%b wanted 010xxx", PHASES);
                end
            end
            if (j == 7) begin
                testsRun++;
                if (PHASES !== 6'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL restart_last_zero: phases=%b wanted 000000", PHASES);
                end
            end
            if (j == 8) begin
                testsRun++;
                if ((PHASES & 6'b111110) !== 6'b010000 || commutation_strobe !== 1'b1) begin
                    testsFailed++;
                    $display("[TB] FAIL restart_run: phases=%b strobe=%b, wanted 01000x/1", PHASES, commutation_strobe);
                end
            end
        end
        testsRun++;
        if (zeroCount !== 6 || strobeCount !== 1) begin
            testsFailed++;
            $display("[TB] FAIL restart_window: zeros=%0d strobes=%0d, wanted 6/1", zeroCount, strobeCount);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; direction = 1'b0; duty = 4'd0;
        setHall(3'b000);
        test_reset();
        test_filter();
        test_reverse_pwm();
        test_invalid();
        test_stall();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
